// File: rtl/i8088_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module : i8088_bus_pkg
// Brief  : Shared widths, wait limit and bus-phase encoding for the 8088 master.
// Rev    : 1.0  initial release
// ============================================================================
package i8088_bus_pkg;

    localparam int ADDR_W   = 20;
    localparam int DATA_W   = 8;
    localparam int AHI_W    = ADDR_W - 8;
    localparam int WAIT_W   = 4;
    localparam int MAX_WAIT = 15;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_TW   = 3'd4,
        ST_T4   = 3'd5
    } state_t;

    // I/O space only decodes 64K ports, so the top nibble is forced low.
    function automatic logic [ADDR_W-1:0] bus_addr(input logic iom,
                                                   input logic [ADDR_W-1:0] addr);
        return iom ? {4'h0, addr[15:0]} : addr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i8088_wait_timer.sv
`default_nettype none
// ============================================================================
// Module : i8088_wait_timer
// Brief  : Wait-state counter with clear, increment and expiry flag.
// Rev    : 1.0  initial release
// ============================================================================
module i8088_wait_timer
    import i8088_bus_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expired
);

    logic [WAIT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == WAIT_W'(MAX_WAIT));

endmodule
`default_nettype wire

// File: rtl/i8088_bus_master.sv
`default_nettype none
// ============================================================================
// Module : i8088_bus_master
// Brief  : Single-request 8088 minimum-mode bus cycle generator (T1-T4, TW).
// Rev    : 1.0  initial release
// ============================================================================
module i8088_bus_master
    import i8088_bus_pkg::*;
(
    input  logic                CLK,
    input  logic                RESET,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic                req_iom,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                ALE,
    output logic [AHI_W-1:0]    A,
    inout  wire  [DATA_W-1:0]   AD,
    output logic                IOM,
    output logic                RD_n,
    output logic                WR_n,
    output logic                DTR,
    output logic                DEN_n,
    input  logic                READY
);

    state_t              r_state;
    logic                r_ready;
    logic                r_rsp_valid;
    logic                r_rsp_err;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_ale;
    logic [AHI_W-1:0]    r_a;
    logic                r_iom;
    logic                r_dtr;
    logic                r_rd_n;
    logic                r_wr_n;
    logic                r_den_n;
    logic                r_ad_oe;
    logic [DATA_W-1:0]   r_ad_out;
    logic                r_write;
    logic [DATA_W-1:0]   r_wdata;

    state_t              w_next;
    logic                w_accept;
    logic                w_expired;
    logic                w_timeout;
    logic                w_strobe;
    logic                w_capture;
    logic [ADDR_W-1:0]   w_bus_addr;

    assign w_accept   = req_valid & r_ready;
    assign w_timeout  = (r_state == ST_TW) & ~READY & w_expired;
    assign w_capture  = ((r_state == ST_T3) || (r_state == ST_TW)) & READY & ~r_write;
    assign w_bus_addr = bus_addr(req_iom, req_addr);
    assign w_strobe   = (w_next == ST_T2) || (w_next == ST_T3) || (w_next == ST_TW);

    i8088_wait_timer u_wait_timer (
        .clk       (CLK),
        .rst_n     (RESET),
        .i_clr     (r_state == ST_T2),
        .i_inc     (w_next == ST_TW),
        .o_expired (w_expired)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: w_next = w_accept ? ST_T1 : ST_IDLE;
            ST_T1:   w_next = ST_T2;
            ST_T2:   w_next = ST_T3;
            ST_T3:   w_next = READY ? ST_T4 : ST_TW;
            ST_TW:   w_next = (READY || w_expired) ? ST_T4 : ST_TW;
            ST_T4:   w_next = w_accept ? ST_T1 : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Every pin is registered from the upcoming phase so it changes on the edge.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rdata     <= '0;
            r_ale       <= 1'b0;
            r_a         <= '0;
            r_iom       <= 1'b0;
            r_dtr       <= 1'b0;
            r_rd_n      <= 1'b1;
            r_wr_n      <= 1'b1;
            r_den_n     <= 1'b1;
            r_ad_oe     <= 1'b0;
            r_ad_out    <= '0;
            r_write     <= 1'b0;
            r_wdata     <= '0;
        end else begin
            r_state     <= w_next;
            r_ready     <= (w_next == ST_IDLE) || (w_next == ST_T4);
            r_ale       <= (w_next == ST_T1);
            r_rsp_valid <= (w_next == ST_T4);
            r_rsp_err   <= w_timeout;
            r_rd_n      <= ~(w_strobe & ~r_write);
            r_wr_n      <= ~(w_strobe & r_write);
            r_den_n     <= ~w_strobe;

            if (w_accept) begin
                r_write <= req_write;
                r_wdata <= req_wdata;
            end

            if (w_capture) begin
                r_rdata <= AD;
            end

            case (w_next)
                ST_IDLE: begin
                    r_a     <= '0;
                    r_iom   <= 1'b0;
                    r_dtr   <= 1'b0;
                    r_ad_oe <= 1'b0;
                end
                ST_T1: begin
                    r_a      <= w_bus_addr[ADDR_W-1:8];
                    r_iom    <= req_iom;
                    r_dtr    <= req_write;
                    r_ad_oe  <= 1'b1;
                    r_ad_out <= w_bus_addr[7:0];
                end
                default: begin
                    r_ad_oe  <= r_write;
                    r_ad_out <= r_wdata;
                end
            endcase
        end
    end

    assign AD        = r_ad_oe ? r_ad_out : {DATA_W{1'bz}};
    assign req_ready = r_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rdata;
    assign ALE       = r_ale;
    assign A         = r_a;
    assign IOM       = r_iom;
    assign DTR       = r_dtr;
    assign RD_n      = r_rd_n;
    assign WR_n      = r_wr_n;
    assign DEN_n     = r_den_n;

endmodule
`default_nettype wire

// File: tb/tb_i8088_bus_master.sv
`default_nettype none
// ============================================================================
// Module : tb_i8088_bus_master
// Brief  : Transaction-level model plus directed checks for i8088_bus_master.
// Rev    : 1.0  initial release
// ============================================================================
module tb_i8088_bus_master;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic        req_iom = 1'b0;
    logic [19:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err, ALE, IOM, RD_n, WR_n, DTR, DEN_n;
    logic [7:0]  rsp_rdata;
    logic [11:0] A;
    wire  [7:0]  AD;
    logic        READY;

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction model: cycle offset since acceptance (1 = T1) and total length.
    int          m_off = 0, m_len = 0, m_nwait = 0, m_acc_cnt = 0;
    logic        m_ready = 1'b0, m_err = 1'b0, m_acc_now = 1'b0;
    logic        m_write = 1'b0, m_iom = 1'b0;
    logic [19:0] m_addr = '0;
    logic [7:0]  m_wdata = '0, m_resp = '0, m_rdata = '0;
    int          s_nwait = 0;
    logic [7:0]  s_resp = '0;

    logic        tb_ready = 1'b1, tb_ad_oe = 1'b1;
    logic [7:0]  tb_ad_val = 8'h96;

    int cyc = 0, acc_cyc = 0, last_lat = 0, last_ale = 0, ale_gap = 0, n_rsp = 0;
    logic last_err = 1'b0;

    assign READY = tb_ready;
    assign AD    = tb_ad_oe ? tb_ad_val : 8'hzz;

    always #5 CLK = ~CLK;

    i8088_bus_master dut (
        .CLK(CLK), .RESET(RESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_iom(req_iom), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ALE(ALE), .A(A), .AD(AD), .IOM(IOM), .RD_n(RD_n), .WR_n(WR_n),
        .DTR(DTR), .DEN_n(DEN_n), .READY(READY)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            m_off   = 0;
            m_len   = 0;
            m_ready = 1'b0;
            m_err   = 1'b0;
            m_rdata = '0;
        end else begin
            m_acc_now = req_valid && m_ready;
            if (m_off >= 3 && m_off == m_len - 1 && !m_write && !m_err)
                m_rdata = m_resp;
            if (m_off == 0 || m_off == m_len) begin
                if (m_acc_now) begin
                    m_write = req_write;
                    m_iom   = req_iom;
                    m_addr  = req_iom ? {4'h0, req_addr[15:0]} : req_addr;
                    m_wdata = req_wdata;
                    m_resp  = s_resp;
                    m_nwait = s_nwait;
                    m_len   = 4 + ((s_nwait > 15) ? 15 : s_nwait);
                    m_err   = (s_nwait >= 16);
                    m_off   = 1;
                    m_acc_cnt++;
                end else begin
                    m_off = 0;
                end
            end else begin
                m_off++;
            end
            m_ready = (m_off == 0) || (m_off == m_len);
        end
    end

    // Responder: READY low for the requested number of samples; drives read data,
    // otherwise a probe byte whenever the master must have released AD.
    always @(posedge CLK or negedge RESET) begin
        #1;
        tb_ready  = !((m_off >= 3) && (m_off < m_len) && ((m_off - 3) < m_nwait));
        tb_ad_oe  = (m_off == 0) || (!m_write && m_off >= 2);
        tb_ad_val = (!m_write && m_off >= 2 && m_off < m_len) ? m_resp : 8'h96;
    end

    always @(negedge CLK) begin
        logic       e_strobe, e_valid;
        logic [7:0] e_ad;
        e_strobe = (m_off >= 2) && (m_off < m_len);
        e_valid  = (m_off != 0) && (m_off == m_len);
        if (m_off == 1)                  e_ad = m_addr[7:0];
        else if (m_write && m_off >= 2)  e_ad = m_wdata;
        else                             e_ad = tb_ad_val;
        chk("req_ready", 32'(req_ready), 32'(m_ready));
        chk("ALE",       32'(ALE),       32'(m_off == 1));
        chk("A",         32'(A),         (m_off == 0) ? 32'd0 : 32'(m_addr[19:8]));
        chk("IOM",       32'(IOM),       (m_off == 0) ? 32'd0 : 32'(m_iom));
        chk("DTR",       32'(DTR),       (m_off == 0) ? 32'd0 : 32'(m_write));
        chk("RD_n",      32'(RD_n),      32'(!(e_strobe && !m_write)));
        chk("WR_n",      32'(WR_n),      32'(!(e_strobe && m_write)));
        chk("DEN_n",     32'(DEN_n),     32'(!e_strobe));
        chk("AD",        32'(AD),        32'(e_ad));
        chk("rsp_valid", 32'(rsp_valid), 32'(e_valid));
        chk("rsp_err",   32'(rsp_err),   32'(e_valid && m_err));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
        if (rsp_valid) begin
            last_lat = cyc - acc_cyc;
            last_err = rsp_err;
            n_rsp++;
        end
        if (req_valid && req_ready) acc_cyc = cyc;
        if (ALE) begin
            ale_gap  = cyc - last_ale;
            last_ale = cyc;
        end
        cyc++;
    end

    task automatic issue(input logic w, input logic iom, input logic [19:0] a,
                         input logic [7:0] d, input int nw, input logic [7:0] rb);
        int start;
        int g;
        req_write = w;
        req_iom   = iom;
        req_addr  = a;
        req_wdata = d;
        s_nwait   = nw;
        s_resp    = rb;
        req_valid = 1'b1;
        start     = m_acc_cnt;
        g         = 0;
        while (m_acc_cnt == start && g < 60) begin
            @(posedge CLK); #2;
            g++;
        end
        chk("accepted", 32'(m_acc_cnt - start), 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (m_off != 0 && g < 60) begin
            @(posedge CLK); #2;
            g++;
        end
        @(posedge CLK); #2;
        chk("idle_reached", 32'(m_off), 32'd0);
    endtask

    task automatic step();
        @(posedge CLK); #2;
    endtask

    initial begin
        int rsp_base;
        #1 RESET = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_RD_n", 32'(RD_n), 32'd1);
        chk("rst_DEN_n", 32'(DEN_n), 32'd1);
        chk("rst_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        #1 RESET = 1'b1;
        #1 chk("ready_before_clk", 32'(req_ready), 32'd0);
        step();
        chk("ready_after_clk", 32'(req_ready), 32'd1);

        // Memory read 0x12345, no waits.
        issue(1'b0, 1'b0, 20'h12345, 8'h00, 0, 8'h5A);
        chk("rd_T1_ALE", 32'(ALE), 32'd1);
        chk("rd_T1_AD", 32'(AD), 32'h45);
        chk("rd_T1_A", 32'(A), 32'h123);
        step(); chk("rd_T2_RD_n", 32'(RD_n), 32'd0);
        step(); chk("rd_T3_RD_n", 32'(RD_n), 32'd0);
        step(); chk("rd_T4_valid", 32'(rsp_valid), 32'd1);
        chk("rd_T4_rdata", 32'(rsp_rdata), 32'h5A);
        wait_idle();
        chk("rd_latency", 32'(last_lat), 32'd4);

        // I/O write 0xFF04 (upper address nibble must be dropped).
        issue(1'b1, 1'b1, 20'hAFF04, 8'hA5, 0, 8'h00);
        chk("io_T1_IOM", 32'(IOM), 32'd1);
        chk("io_T1_DTR", 32'(DTR), 32'd1);
        chk("io_T1_A", 32'(A), 32'h0FF);
        chk("io_T1_AD", 32'(AD), 32'h04);
        step(); chk("io_T2_WR_n", 32'(WR_n), 32'd0);
        chk("io_T2_AD", 32'(AD), 32'hA5);
        step(); chk("io_T3_WR_n", 32'(WR_n), 32'd0);
        step(); chk("io_T4_AD", 32'(AD), 32'hA5);
        chk("io_T4_err", 32'(rsp_err), 32'd0);
        chk("io_T4_valid", 32'(rsp_valid), 32'd1);
        wait_idle();

        // Read with three wait states.
        issue(1'b0, 1'b0, 20'h01234, 8'h00, 3, 8'h3C);
        wait_idle();
        chk("w3_latency", 32'(last_lat), 32'd7);
        chk("w3_rdata", 32'(rsp_rdata), 32'h3C);

        // READY stuck low: timeout after 15 wait states, read data untouched.
        issue(1'b0, 1'b0, 20'h0ABCD, 8'h00, 40, 8'hEE);
        wait_idle();
        chk("to_latency", 32'(last_lat), 32'd19);
        chk("to_err", 32'(last_err), 32'd1);
        chk("to_rdata", 32'(rsp_rdata), 32'h3C);

        // Exactly 15 wait states then READY: completes without error.
        issue(1'b0, 1'b0, 20'h0BEEF, 8'h00, 15, 8'h81);
        wait_idle();
        chk("w15_latency", 32'(last_lat), 32'd19);
        chk("w15_err", 32'(last_err), 32'd0);
        chk("w15_rdata", 32'(rsp_rdata), 32'h81);

        // Back-to-back write then read.
        issue(1'b1, 1'b0, 20'h80000, 8'h11, 0, 8'h00);
        issue(1'b0, 1'b0, 20'h00010, 8'h00, 0, 8'h77);
        wait_idle();
        chk("b2b_ale_gap", 32'(ale_gap), 32'd4);
        chk("b2b_rdata", 32'(rsp_rdata), 32'h77);

        // Reset during T2 of a write.
        rsp_base = n_rsp;
        issue(1'b1, 1'b0, 20'h00321, 8'h5C, 0, 8'h00);
        step();
        #1 RESET = 1'b0;
        #2;
        chk("abort_WR_n", 32'(WR_n), 32'd1);
        chk("abort_DEN_n", 32'(DEN_n), 32'd1);
        chk("abort_AD", 32'(AD), 32'h96);
        chk("abort_A", 32'(A), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd0);
        chk("abort_rdata", 32'(rsp_rdata), 32'd0);
        step();
        RESET = 1'b1;
        step();
        chk("abort_no_rsp", 32'(n_rsp - rsp_base), 32'd0);
        issue(1'b1, 1'b0, 20'h00321, 8'h5C, 0, 8'h00);
        chk("restart_ALE", 32'(ALE), 32'd1);
        chk("restart_AD", 32'(AD), 32'h21);
        wait_idle();
        chk("restart_one_rsp", 32'(n_rsp - rsp_base), 32'd1);

        repeat (3) @(posedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/i8088_bus_master.md
I8088_BUS_MASTER -- requirements
Module: i8088_bus_master

Interface
REQ-001 CLK  input  1  system clock; all state changes on rising edge.
REQ-002 RESET  input  1  asynchronous, active-low reset.
REQ-003 req_valid  input  1  client requests one bus cycle.
REQ-004 req_ready  output  1  master accepts the request this cycle.
REQ-005 req_write  input  1  1 = write cycle, 0 = read cycle.
REQ-006 req_iom  input  1  1 = I/O space, 0 = memory space.
REQ-007 req_addr  input  20  byte address; I/O cycles use bits [15:0], bits [19:16] driven 0.
REQ-008 req_wdata  input  8  write data.
REQ-009 rsp_valid  output  1  one-cycle pulse: cycle complete.
REQ-010 rsp_rdata  output  8  read data, valid with rsp_valid on reads, held until next read.
REQ-011 rsp_err  output  1  valid with rsp_valid: wait-state timeout abort.
REQ-012 ALE  output  1  address latch enable.
REQ-013 A  output  12  address bits [19:8].
REQ-014 AD  inout  8  multiplexed address/data; tri-stated when not driven.
REQ-015 IOM  output  1  1 = I/O cycle.
REQ-016 RD_n, WR_n  output  1 each  active-low strobes.
REQ-017 DTR  output  1  1 = transmit (write), 0 = receive.
REQ-018 DEN_n  output  1  active-low transceiver enable.
REQ-019 READY  input  1  responder ready; 0 inserts wait states.

Function
REQ-020 States SHALL be IDLE, T1, T2, T3, TW, T4.
REQ-021 Handshake: transfer occurs when req_valid && req_ready; req_ready SHALL be 1 only in IDLE and T4.
REQ-022 On transfer, req_write/iom/addr/wdata SHALL be registered and the next state SHALL be T1.
REQ-023 T1: ALE=1, AD=addr[7:0], A=addr[19:8], IOM and DTR set from the request; all strobes inactive.
REQ-024 T2 read: ALE=0, AD=Z, RD_n=0, DEN_n=0.
REQ-025 T2 write: ALE=0, AD=wdata, WR_n=0, DEN_n=0.
REQ-026 A, IOM and DTR SHALL stay stable from T1 through T4.
REQ-027 T3 and TW: strobes held; READY sampled; READY=1 -> T4, READY=0 -> TW.
REQ-028 Wait counter (4 bits) SHALL clear in T2 and increment per TW; READY=0 while the counter is 15 -> T4 with rsp_err=1.
REQ-029 Read data SHALL be captured from AD on the edge leaving T3/TW with READY=1; not captured on a timeout.
REQ-030 T4: RD_n=WR_n=DEN_n=1; AD=Z on reads; write data held on AD; rsp_valid=1.
REQ-031 From T4: accepted request -> T1 (back-to-back, 4 clocks per zero-wait cycle); otherwise IDLE.
REQ-032 IDLE: AD=Z, ALE=0, strobes inactive, DTR=0, IOM=0.
REQ-033 Minimum latency from acceptance to rsp_valid SHALL be 4 clocks; +1 per wait state.

Reset
REQ-034 RESET low SHALL force IDLE immediately, mid-cycle included: ALE=0, RD_n=WR_n=DEN_n=1, AD=Z, A=0, IOM=0, DTR=0, req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, wait counter 0.
REQ-035 An aborted cycle SHALL produce no rsp_valid; req_ready SHALL go 1 on the first clock after RESET deasserts.

Structure
REQ-036 Package i8088_bus_pkg SHALL hold the state enum, MAX_WAIT=15, and address/data width constants.
REQ-037 Sub-module i8088_wait_timer (4-bit wait counter with clear/increment/expired) is natural; everything else is in one FSM.

Verification
REQ-038 Memory read 0x12345, READY=1 -> ALE=1 in T1 with AD=0x45, A=0x123; RD_n=0 in T2-T3; rsp_valid in the 4th clock; rsp_rdata equals the responder byte.
REQ-039 I/O write 0xFF04 data 0xA5, READY=1 -> IOM=1, DTR=1, WR_n=0 in T2-T3, AD=0xA5 through T4, rsp_err=0.
REQ-040 Memory read with READY=0 for 3 cycles -> 3 TW states; rsp_valid 7 clocks after acceptance.
REQ-041 READY held 0 -> 15 TW states, then T4 with rsp_valid=1, rsp_err=1, rsp_rdata unchanged.
REQ-042 Two back-to-back requests (write 0x80000, read 0x00010) -> second T1 immediately follows first T4; ALE pulses 4 clocks apart.
REQ-043 RESET asserted during T2 of a write -> WR_n=1, AD=Z at once; no rsp_valid; next request starts cleanly at T1.
